// File: rtl/byte_serializer.sv
// Parallel-to-serial converter: takes one DATA_W-bit word over a valid/ready
// handshake and shifts it out one bit per ser_en strobe, with gapless reload.
module byte_serializer #(
    parameter int DATA_W    = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              ser_en,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              ser_last,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_shift_s;
    logic              last_s;
    logic              ready_s;
    logic              accept_s;
    logic              out_bit_s;

    assign in_shift_s = (state_q == ST_SHIFT);
    assign last_s     = (cnt_q == CNT_LAST);
    assign accept_s   = in_valid && ready_s;

    // Ready depends only on registered state and ser_en; held low during reset.
    always_comb begin
        ready_s = 1'b0;
        case (state_q)
            ST_IDLE:  ready_s = 1'b1;
            ST_SHIFT: ready_s = last_s && ser_en;
            default:  ready_s = 1'b0;
        endcase
        if (!rst_n) begin
            ready_s = 1'b0;
        end else begin
            ready_s = ready_s;
        end
    end

    // Output-end bit selection for the configured bit order.
    always_comb begin
        out_bit_s = 1'b0;
        if (LSB_FIRST) begin
            out_bit_s = shift_q[0];
        end else begin
            out_bit_s = shift_q[DATA_W-1];
        end
    end

    // Next-state logic: load on accept, shift on ser_en, reload or retire at the last bit.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_SHIFT;
                    shift_d = in_data;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!ser_en) begin
                    state_d = ST_SHIFT;
                end else if (!last_s) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (LSB_FIRST) begin
                        shift_d = {1'b0, shift_q[DATA_W-1:1]};
                    end else begin
                        shift_d = {shift_q[DATA_W-2:0], 1'b0};
                    end
                end else if (accept_s) begin
                    // Gapless: the next word replaces the finished one on the same edge.
                    shift_d = in_data;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                    shift_d = {DATA_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                end
            end
            default: begin
                state_d = ST_IDLE;
                shift_d = {DATA_W{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State registers; asynchronous reset discards any partially sent word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= {DATA_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = ready_s;
    assign ser_valid = in_shift_s;
    assign busy      = in_shift_s;
    assign ser_out   = in_shift_s && out_bit_s;
    assign ser_last  = in_shift_s && last_s;

endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench for byte_serializer: drives an LSB-first and an MSB-first
// instance with identical stimulus and compares against hand-derived bits.
module tb_byte_serializer;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       ser_en;
    logic       l_ready, l_out, l_valid, l_last, l_busy;
    logic       m_ready, m_out, m_valid, m_last, m_busy;

    int n_checks;
    int n_fail;

    byte_serializer #(.DATA_W(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(l_ready), .ser_en(ser_en), .ser_out(l_out),
        .ser_valid(l_valid), .ser_last(l_last), .busy(l_busy)
    );

    byte_serializer #(.DATA_W(8), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(m_ready), .ser_en(ser_en), .ser_out(m_out),
        .ser_valid(m_valid), .ser_last(m_last), .busy(m_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bit slot of word d at position k on both instances.
    task automatic check_slot(input string tag, input logic [7:0] d, input int k, input logic rdy);
        logic [7:0] w;
        w = d;
        check_eq({tag, " lsb out"},   {31'd0, l_out},   {31'd0, w[k]});
        check_eq({tag, " msb out"},   {31'd0, m_out},   {31'd0, w[7-k]});
        check_eq({tag, " lsb valid"}, {31'd0, l_valid}, 32'd1);
        check_eq({tag, " msb valid"}, {31'd0, m_valid}, 32'd1);
        check_eq({tag, " lsb last"},  {31'd0, l_last},  (k == 7) ? 32'd1 : 32'd0);
        check_eq({tag, " msb last"},  {31'd0, m_last},  (k == 7) ? 32'd1 : 32'd0);
        check_eq({tag, " busy"},      {30'd0, l_busy, m_busy}, 32'd3);
        check_eq({tag, " ready"},     {30'd0, l_ready, m_ready}, rdy ? 32'd3 : 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, " valid"}, {30'd0, l_valid, m_valid}, 32'd0);
        check_eq({tag, " out"},   {30'd0, l_out, m_out},     32'd0);
        check_eq({tag, " last"},  {30'd0, l_last, m_last},   32'd0);
        check_eq({tag, " busy"},  {30'd0, l_busy, m_busy},   32'd0);
        check_eq({tag, " ready"}, {30'd0, l_ready, m_ready}, 32'd3);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        ser_en   = 1'b0;

        // Reset state, with a pending request that must not be acknowledged.
        #2;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        ser_en   = 1'b1;
        #1;
        check_eq("rst valid", {30'd0, l_valid, m_valid}, 32'd0);
        check_eq("rst out",   {30'd0, l_out, m_out},     32'd0);
        check_eq("rst last",  {30'd0, l_last, m_last},   32'd0);
        check_eq("rst busy",  {30'd0, l_busy, m_busy},   32'd0);
        check_eq("rst ready", {30'd0, l_ready, m_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("idle ready", {30'd0, l_ready, m_ready}, 32'd3);

        // Single word A5, accepted at the first edge.
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            check_slot("a5", 8'hA5, i, (i == 7));
            tick();
        end
        check_idle("a5 end");

        // Back-to-back 0F then F0 with no gap.
        in_data  = 8'h0F;
        in_valid = 1'b1;
        tick();
        in_data = 8'hF0;
        for (int i = 0; i < 16; i++) begin
            check_slot("b2b", (i < 8) ? 8'h0F : 8'hF0, i % 8, ((i % 8) == 7));
            tick();
            if (i == 7) in_valid = 1'b0;
        end
        check_idle("b2b end");

        // 81 at half bit rate: each bit held for two cycles.
        in_data  = 8'h81;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ser_en = (i % 2 == 1);
            #1;
            check_slot("half", 8'h81, i / 2, (i == 15));
            tick();
        end
        ser_en = 1'b1;
        check_idle("half end");

        // C3 on both bit orders.
        in_data  = 8'hC3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_slot("c3", 8'hC3, i, (i == 7));
            tick();
        end
        check_idle("c3 end");

        // Asynchronous reset in the middle of FF.
        in_data  = 8'hFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_slot("ff", 8'hFF, i, 1'b0);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst valid", {30'd0, l_valid, m_valid}, 32'd0);
        check_eq("arst out",   {30'd0, l_out, m_out},     32'd0);
        check_eq("arst busy",  {30'd0, l_busy, m_busy},   32'd0);
        check_eq("arst ready", {30'd0, l_ready, m_ready}, 32'd0);
        #1;
        rst_n = 1'b1;
        #1;
        check_idle("post rst");
        for (int i = 0; i < 6; i++) begin
            tick();
            check_idle("no residue");
        end
        in_data  = 8'h01;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_slot("01", 8'h01, i, (i == 7));
            tick();
        end
        check_idle("01 end");

        // Requests while mid-word are refused and cannot corrupt the word.
        in_data  = 8'h3C;
        in_valid = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            in_valid = (i >= 2 && i <= 5);
            in_data  = 8'($urandom_range(0, 255));
            #1;
            check_slot("busy req", 8'h3C, i, (i == 7));
            tick();
        end
        in_valid = 1'b0;
        check_idle("busy req end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
